me_slide_window_fifo: RTL and testbench

Byte-granular sliding-window buffer for the motion-estimation reference-pixel path. It accepts narrow pixel words from the reference fetch and presents a wide, byte-aligned pixel window to the SAD array. On each consumed window it advances by a runtime-selectable number of pixels. This is the parametrised, flow-controlled successor to the fixed 1-byte shift stages in the pixel chain. It adds depth, variable step, backpressure, level reporting and flush.

---
 rtl/me_slide_window_fifo.sv | 102 ++++++++++
 tb/tb_me_slide_window_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/me_slide_window_fifo.sv
// Byte-granular sliding-window buffer: narrow pixel words in, wide byte-aligned window out,
// advancing by a runtime-selected step on every consumed window.
module me_slide_window_fifo #(
  parameter int PIX_W     = 8,
  parameter int IN_PIX    = 4,
  parameter int WIN_PIX   = 16,
  parameter int DEPTH_PIX = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               flush_i,
  input  logic [IN_PIX*PIX_W-1:0]            in_data_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic [WIN_PIX*PIX_W-1:0]           out_data_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  input  logic [$clog2(WIN_PIX):0]           step_i,
  output logic [$clog2(DEPTH_PIX+1)-1:0]     level_o
);

  localparam int STEP_W  = $clog2(WIN_PIX) + 1;
  localparam int LVL_W   = $clog2(DEPTH_PIX + 1);
  localparam int STORE_W = DEPTH_PIX * PIX_W;
  localparam int IN_W    = IN_PIX * PIX_W;

  localparam logic [LVL_W-1:0]  WIN_LVL      = LVL_W'(WIN_PIX);
  localparam logic [LVL_W-1:0]  IN_LVL       = LVL_W'(IN_PIX);
  localparam logic [LVL_W-1:0]  PUSH_MAX_LVL = LVL_W'(DEPTH_PIX - IN_PIX);
  localparam logic [STEP_W-1:0] WIN_STEP     = STEP_W'(WIN_PIX);

  logic [STORE_W-1:0] store_r;
  logic [STORE_W-1:0] store_nxt_s;
  logic [STORE_W-1:0] shifted_s;
  logic [STORE_W-1:0] ins_data_s;
  logic [STORE_W-1:0] ins_mask_s;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [LVL_W-1:0]   step_eff_s;
  logic [LVL_W-1:0]   base_s;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               push_s;
  logic               pop_s;

  // Ready does not count a same-cycle pop, which keeps the push slot in range by construction.
  assign in_ready_s  = (level_r <= PUSH_MAX_LVL) && !flush_i && rst_n_i;
  assign out_valid_s = (level_r >= WIN_LVL) && !flush_i && rst_n_i;
  assign push_s      = in_valid_i && in_ready_s;
  assign pop_s       = out_valid_s && out_ready_i;

  // Effective pop step: zero without a pop, otherwise step_i clamped to the window width.
  always_comb begin
    step_eff_s = {LVL_W{1'b0}};
    if (pop_s) begin
      if (step_i > WIN_STEP) begin
        step_eff_s = WIN_LVL;
      end else begin
        step_eff_s = LVL_W'(step_i);
      end
    end else begin
      step_eff_s = {LVL_W{1'b0}};
    end
  end

  // Next storage/level: shift out the popped pixels, then drop the new word right after the survivors.
  always_comb begin
    shifted_s   = store_r >> (int'(step_eff_s) * PIX_W);
    base_s      = level_r - step_eff_s;
    ins_data_s  = {{(STORE_W-IN_W){1'b0}}, in_data_i} << (int'(base_s) * PIX_W);
    ins_mask_s  = {{(STORE_W-IN_W){1'b0}}, {IN_W{1'b1}}} << (int'(base_s) * PIX_W);
    store_nxt_s = shifted_s;
    level_nxt_s = base_s;
    if (push_s) begin
      store_nxt_s = (shifted_s & ~ins_mask_s) | ins_data_s;
      level_nxt_s = base_s + IN_LVL;
    end else begin
      store_nxt_s = shifted_s;
      level_nxt_s = base_s;
    end
  end

  // State registers; reset and flush both empty the buffer and zero every pixel.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      store_r <= {STORE_W{1'b0}};
      level_r <= {LVL_W{1'b0}};
    end else if (flush_i) begin
      store_r <= {STORE_W{1'b0}};
      level_r <= {LVL_W{1'b0}};
    end else begin
      store_r <= store_nxt_s;
      level_r <= level_nxt_s;
    end
  end

  assign out_data_o  = store_r[WIN_PIX*PIX_W-1:0];
  assign level_o     = level_r;
  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_s;

endmodule

// File: tb/tb_me_slide_window_fifo.sv
// Scoreboard bench for me_slide_window_fifo: a byte-queue model predicts each cycle's
// handshake flags and the next window/level; a separate monitor compares them.
module tb_me_slide_window_fifo;

  localparam int PIX_W     = 8;
  localparam int IN_PIX    = 4;
  localparam int WIN_PIX   = 16;
  localparam int DEPTH_PIX = 32;
  localparam int STEP_W    = $clog2(WIN_PIX) + 1;
  localparam int LVL_W     = $clog2(DEPTH_PIX + 1);

  logic                         clk = 1'b0;
  logic                         rst_n_i = 1'b0;
  logic                         flush_i = 1'b0;
  logic [IN_PIX*PIX_W-1:0]      in_data_i = '0;
  logic                         in_valid_i = 1'b0;
  logic                         in_ready_o;
  logic [WIN_PIX*PIX_W-1:0]     out_data_o;
  logic                         out_valid_o;
  logic                         out_ready_i = 1'b0;
  logic [STEP_W-1:0]            step_i = '0;
  logic [LVL_W-1:0]             level_o;

  me_slide_window_fifo #(
    .PIX_W(PIX_W), .IN_PIX(IN_PIX), .WIN_PIX(WIN_PIX), .DEPTH_PIX(DEPTH_PIX)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .step_i(step_i), .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                     rdy;
    logic                     vld;
    int                       lvl;
    logic [WIN_PIX*PIX_W-1:0] win;
  } exp_t;

  exp_t        sb[$];
  byte unsigned mq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  next_byte = 8'h00;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, advance the queue model, queue the expectation.
  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [31:0] d,
                       input logic ordy, input int step, output logic fired);
    exp_t e;
    int   L;
    int   s;
    logic pop;
    @(negedge clk);
    rst_n_i = rst; flush_i = fl; in_valid_i = iv; in_data_i = d;
    out_ready_i = ordy; step_i = STEP_W'(step);
    L     = mq.size();
    e.rdy = rst && !fl && (L <= DEPTH_PIX - IN_PIX);
    e.vld = rst && !fl && (L >= WIN_PIX);
    fired = 1'b0;
    if (!rst || fl) begin
      mq.delete();
    end else begin
      fired = iv && e.rdy;
      pop   = ordy && e.vld;
      s     = pop ? ((step > WIN_PIX) ? WIN_PIX : step) : 0;
      for (int k = 0; k < s; k++) void'(mq.pop_front());
      if (fired) for (int k = 0; k < IN_PIX; k++) mq.push_back(d[8*k +: 8]);
    end
    e.lvl = mq.size();
    e.win = '0;
    for (int k = 0; k < WIN_PIX && k < mq.size(); k++) e.win[8*k +: 8] = mq[k];
    sb.push_back(e);
  endtask

  function automatic logic [31:0] inc_word(input logic [7:0] base);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = base + 8'(k);
    return w;
  endfunction

  // Monitor: handshake flags are checked before the edge, window and level just after it.
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("in_ready", 128'(in_ready_o), 128'(mon_e.rdy));
      chk("out_valid", 128'(out_valid_o), 128'(mon_e.vld));
      #1;
      chk("level", 128'(level_o), 128'(mon_e.lvl));
      chk("window", out_data_o, mon_e.win);
    end
  end

  task automatic push_inc(input logic ordy, input int step);
    logic f;
    drive(1'b1, 1'b0, 1'b1, inc_word(next_byte), ordy, step, f);
    if (f) next_byte = next_byte + 8'd4;
  endtask

  task automatic do_flush();
    logic f;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0, f);
    next_byte = 8'h00;
  endtask

  initial begin
    logic f;
    // Reset, then fill a window with 0x00..0x0F while the consumer stalls.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, f);
    drive(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 0, f);
    for (int i = 0; i < 4; i++) push_inc(1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, f);

    // Streaming push with step-1 pops every cycle, long enough for ready to drop.
    do_flush();
    for (int i = 0; i < 24; i++) push_inc(1'b1, 1);

    // Whole-window pop with a same-cycle push.
    do_flush();
    for (int i = 0; i < 4; i++) push_inc(1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 32'h13121110, 1'b1, 16, f);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, f);

    // Fill to capacity, attempt an extra push, then free one word.
    do_flush();
    for (int i = 0; i < 9; i++) push_inc(1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4, f);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, f);

    // Step 0 re-presents the window; an oversized step is clamped.
    do_flush();
    for (int i = 0; i < 5; i++) push_inc(1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0, f);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 20, f);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 31, f);

    // Flush at L=24 with both handshakes requested, then reset mid-stream.
    do_flush();
    for (int i = 0; i < 6; i++) push_inc(1'b0, 0);
    drive(1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 1'b1, 4, f);
    for (int i = 0; i < 6; i++) push_inc(1'b0, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h11223344, 1'b1, 4, f);
    drive(1'b0, 1'b1, 1'b1, 32'h55667788, 1'b1, 4, f);
    drive(1'b1, 1'b0, 1'b1, 32'h03020100, 1'b0, 0, f);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      logic rst;
      logic fl;
      logic iv;
      logic ordy;
      int   step;
      rst  = ($urandom_range(0, 99) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1) != 0;
      step = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : $urandom_range(0, 31);
      drive(rst, fl, iv, $urandom, ordy, step, f);
    end

    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
